// File: rtl/iob_rr_merge.sv
// ============================================================================
// iob_rr_merge
// ----------------------------------------------------------------------------
// Purpose:
//   This block shares one IOb native-bus slave port between N_MASTERS master
//   ports using round-robin arbitration. A one-cycle arbitration stage
//   registers the grant. An in-order ID FIFO remembers which master issued each
//   outstanding read, so every rvalid/rdata beat goes back to that master.
//
// Ports (master buses are packed, master i sits at slice i):
//   clk_i        in   1                   clock
//   cke_i        in   1                   clock enable (0 = hold all registers)
//   rst_n_i      in   1                   synchronous active-low reset
//   m_avalid_i   in   N_MASTERS           master request valid
//   m_addr_i     in   N_MASTERS*ADDR_W    master address
//   m_wdata_i    in   N_MASTERS*DATA_W    master write data
//   m_wstrb_i    in   N_MASTERS*DATA_W/8  master byte strobes (all zero = read)
//   m_rdata_o    out  N_MASTERS*DATA_W    read data (same value on every slice)
//   m_rvalid_o   out  N_MASTERS           read data valid, routed by FIFO head
//   m_ready_o    out  N_MASTERS           request accepted
//   s_avalid_o   out  1                   slave request valid
//   s_addr_o     out  ADDR_W              slave address
//   s_wdata_o    out  DATA_W              slave write data
//   s_wstrb_o    out  DATA_W/8            slave byte strobes
//   s_rdata_i    in   DATA_W              slave read data
//   s_rvalid_i   in   1                   slave read data valid
//   s_ready_i    in   1                   slave request accepted
//
// Configuration macro:
//   IOB_RR_MERGE_B2B_EN  When defined, an accept that happens while other
//                        masters are requesting re-arbitrates in the same
//                        cycle. The FSM stays in BUSY, which gives one transfer
//                        per cycle under contention. When undefined, every
//                        transfer takes at least two cycles (BUSY then IDLE).
// ============================================================================
module iob_rr_merge #(
    parameter int N_MASTERS = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_OUT   = 4
) (
    input  logic                          clk_i,
    input  logic                          cke_i,
    input  logic                          rst_n_i,
    input  logic [N_MASTERS-1:0]          m_avalid_i,
    input  logic [N_MASTERS*ADDR_W-1:0]   m_addr_i,
    input  logic [N_MASTERS*DATA_W-1:0]   m_wdata_i,
    input  logic [N_MASTERS*DATA_W/8-1:0] m_wstrb_i,
    output logic [N_MASTERS*DATA_W-1:0]   m_rdata_o,
    output logic [N_MASTERS-1:0]          m_rvalid_o,
    output logic [N_MASTERS-1:0]          m_ready_o,
    output logic                          s_avalid_o,
    output logic [ADDR_W-1:0]             s_addr_o,
    output logic [DATA_W-1:0]             s_wdata_o,
    output logic [DATA_W/8-1:0]           s_wstrb_o,
    input  logic [DATA_W-1:0]             s_rdata_i,
    input  logic                          s_rvalid_i,
    input  logic                          s_ready_i
);

    localparam int STRB_W = DATA_W / 8;
    localparam int GW     = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
    localparam int PW     = $clog2(MAX_OUT);
    localparam int CW     = PW + 1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   grant_q, grant_d;
    logic [GW-1:0]   last_grant_q, last_grant_d;
    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [GW-1:0]   id_mem_q [MAX_OUT];
    logic [GW-1:0]   id_mem_d [MAX_OUT];

    logic                 sel_avalid;
    logic [ADDR_W-1:0]    sel_addr;
    logic [DATA_W-1:0]    sel_wdata;
    logic [STRB_W-1:0]    sel_wstrb;
    logic                 sel_is_read;
    logic [N_MASTERS-1:0] grant_onehot;
    logic [N_MASTERS-1:0] head_onehot;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 fwd;
    logic                 accept;
    logic                 push;
    logic                 pop;

`ifdef IOB_RR_MERGE_B2B_EN
    logic [N_MASTERS-1:0] other_req;
`endif

    // Find the first requester strictly after 'start', wrapping around.
    // When the search reaches 'start' again it is the last candidate.
    function automatic logic [GW-1:0] rr_pick(input logic [GW-1:0]        start,
                                              input logic [N_MASTERS-1:0] req);
        logic [GW-1:0] pick;
        logic          found;
        int            idx;
        pick  = start;
        found = 1'b0;
        for (int k = 1; k <= N_MASTERS; k++) begin
            idx = int'(start) + k;
            if (idx >= N_MASTERS) begin
                idx = idx - N_MASTERS;
            end
            if (!found && req[idx]) begin
                pick  = GW'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    // Payload mux for the granted master. A loop compare avoids indexing
    // past N_MASTERS when N_MASTERS is not a power of two.
    always_comb begin
        sel_avalid   = 1'b0;
        sel_addr     = '0;
        sel_wdata    = '0;
        sel_wstrb    = '0;
        grant_onehot = '0;
        head_onehot  = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            if (grant_q == GW'(i)) begin
                sel_avalid      = m_avalid_i[i];
                sel_addr        = m_addr_i[i*ADDR_W +: ADDR_W];
                sel_wdata       = m_wdata_i[i*DATA_W +: DATA_W];
                sel_wstrb       = m_wstrb_i[i*STRB_W +: STRB_W];
                grant_onehot[i] = 1'b1;
            end
            if (id_mem_q[rd_ptr_q] == GW'(i)) begin
                head_onehot[i] = 1'b1;
            end
        end
    end

    // A read is held back while every ID slot is in use. Fullness comes from
    // the registered count, so a pop in this cycle does not help until the
    // next cycle.
    always_comb begin
        sel_is_read = (sel_wstrb == '0);
        fifo_full   = (count_q == CW'(MAX_OUT));
        fifo_empty  = (count_q == '0);
        fwd         = (state_q == BUSY) && sel_avalid && !(sel_is_read && fifo_full);
        accept      = fwd && s_ready_i;
        push        = accept && sel_is_read;
        // If rvalid arrives with nothing outstanding, it is dropped here.
        pop         = s_rvalid_i && !fifo_empty;
    end

    // Arbitration next-state logic.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
`ifdef IOB_RR_MERGE_B2B_EN
        other_req    = m_avalid_i & ~grant_onehot;
`endif
        unique case (state_q)
            IDLE: begin
                if (|m_avalid_i) begin
                    grant_d      = rr_pick(last_grant_q, m_avalid_i);
                    last_grant_d = grant_d;
                    state_d      = BUSY;
                end
            end
            BUSY: begin
                if (accept) begin
`ifdef IOB_RR_MERGE_B2B_EN
                    if (|other_req) begin
                        grant_d      = rr_pick(grant_q, other_req);
                        last_grant_d = grant_d;
                        state_d      = BUSY;
                    end else begin
                        state_d = IDLE;
                    end
`else
                    state_d = IDLE;
`endif
                end else if (!sel_avalid) begin
                    // The master withdrew its request, so nothing is transferred.
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ID FIFO next-state logic. A push is only possible when the FIFO is not
    // full, and a pop only when it is not empty, so the count cannot wrap.
    always_comb begin
        for (int i = 0; i < MAX_OUT; i++) begin
            id_mem_d[i] = id_mem_q[i];
        end
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            id_mem_d[wr_ptr_q] = grant_q;
            wr_ptr_d           = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!push && pop) begin
            count_d = count_q - CW'(1);
        end
    end

    // Outputs. The slave payload is zero in IDLE. The response path is
    // combinational and is steered by the registered FIFO head.
    always_comb begin
        s_avalid_o = fwd;
        s_addr_o   = (state_q == BUSY) ? sel_addr  : '0;
        s_wdata_o  = (state_q == BUSY) ? sel_wdata : '0;
        s_wstrb_o  = (state_q == BUSY) ? sel_wstrb : '0;
        m_ready_o  = accept ? grant_onehot : '0;
        m_rvalid_o = pop ? head_onehot : '0;
        m_rdata_o  = {N_MASTERS{s_rdata_i}};
    end

    // Control registers. Reset is sampled only when the clock enable is high.
    // last_grant resets to the highest index, so master 0 wins first.
    always_ff @(posedge clk_i) begin
        if (cke_i) begin
            if (!rst_n_i) begin
                state_q      <= IDLE;
                grant_q      <= '0;
                last_grant_q <= GW'(N_MASTERS - 1);
                count_q      <= '0;
                wr_ptr_q     <= '0;
                rd_ptr_q     <= '0;
            end else begin
                state_q      <= state_d;
                grant_q      <= grant_d;
                last_grant_q <= last_grant_d;
                count_q      <= count_d;
                wr_ptr_q     <= wr_ptr_d;
                rd_ptr_q     <= rd_ptr_d;
            end
        end
    end

    // ID storage has no reset. An entry is only read after it has been
    // written, because the count guards it.
    always_ff @(posedge clk_i) begin
        if (cke_i) begin
            for (int i = 0; i < MAX_OUT; i++) begin
                id_mem_q[i] <= id_mem_d[i];
            end
        end
    end

endmodule

// File: tb/tb_iob_rr_merge.sv
module tb_iob_rr_merge;

    localparam int N  = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int MO = 4;

    logic              clk = 1'b0;
    logic              cke;
    logic              rst_n;
    logic [N-1:0]      m_av;
    logic [N*AW-1:0]   m_addr;
    logic [N*DW-1:0]   m_wdata;
    logic [N*SW-1:0]   m_wstrb;
    logic [N*DW-1:0]   m_rdata;
    logic [N-1:0]      m_rvalid;
    logic [N-1:0]      m_ready;
    logic              s_avalid;
    logic [AW-1:0]     s_addr;
    logic [DW-1:0]     s_wdata;
    logic [SW-1:0]     s_wstrb;
    logic [DW-1:0]     s_rdata;
    logic              s_rvalid;
    logic              s_ready;

    int checks   = 0;
    int failures = 0;
    bit check_en = 1'b0;

    // Reference model state: whether a master currently holds the grant, who
    // holds it, who won last, and the queue of masters that have reads in flight.
    bit     mdl_busy;
    int     mdl_g;
    int     mdl_last;
    int     idq[$];
    bit     exp_acc;

    iob_rr_merge #(
        .N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .MAX_OUT(MO)
    ) dut (
        .clk_i(clk), .cke_i(cke), .rst_n_i(rst_n),
        .m_avalid_i(m_av), .m_addr_i(m_addr), .m_wdata_i(m_wdata), .m_wstrb_i(m_wstrb),
        .m_rdata_o(m_rdata), .m_rvalid_o(m_rvalid), .m_ready_o(m_ready),
        .s_avalid_o(s_avalid), .s_addr_o(s_addr), .s_wdata_o(s_wdata), .s_wstrb_o(s_wstrb),
        .s_rdata_i(s_rdata), .s_rvalid_i(s_rvalid), .s_ready_i(s_ready)
    );

    always #5 clk = ~clk;

    function automatic bit isRead(int i);
        return (m_wstrb[i*SW +: SW] == '0);
    endfunction

    function automatic int rrNext(int start, logic [N-1:0] mask);
        for (int k = 1; k <= N; k++) begin
            if (mask[(start + k) % N]) return (start + k) % N;
        end
        return start;
    endfunction

    task automatic checkValue(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic setReq(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [SW-1:0] s);
        m_av[i]               = 1'b1;
        m_addr[i*AW +: AW]    = a;
        m_wdata[i*DW +: DW]   = d;
        m_wstrb[i*SW +: SW]   = s;
    endtask

    // Sample on the falling edge and compare every output with the model.
    task automatic checkOutput(input string tag);
        bit           fwd;
        logic [N-1:0] e_ready;
        logic [N-1:0] e_rv;
        @(negedge clk);
        fwd     = mdl_busy && m_av[mdl_g] && !(isRead(mdl_g) && idq.size() == MO);
        exp_acc = fwd && s_ready;
        e_ready = exp_acc ? N'(1 << mdl_g) : '0;
        e_rv    = (s_rvalid && idq.size() > 0) ? N'(1 << idq[0]) : '0;
        if (check_en) begin
            checkValue({tag, "_savalid"}, s_avalid, fwd);
            checkValue({tag, "_saddr"}, s_addr, mdl_busy ? m_addr[mdl_g*AW +: AW] : '0);
            checkValue({tag, "_swdata"}, s_wdata, mdl_busy ? m_wdata[mdl_g*DW +: DW] : '0);
            checkValue({tag, "_swstrb"}, s_wstrb, mdl_busy ? m_wstrb[mdl_g*SW +: SW] : '0);
            checkValue({tag, "_mready"}, m_ready, e_ready);
            checkValue({tag, "_mrvalid"}, m_rvalid, e_rv);
            checkValue({tag, "_mrdata"}, m_rdata, {N{s_rdata}});
        end
    endtask

    // Commit the model for this cycle, cross the rising edge, and then let a
    // master that was just served drop its request.
    task automatic advance();
        bit           drop;
        int           drop_idx;
        logic [N-1:0] others;
        drop     = 1'b0;
        drop_idx = 0;
        others   = '0;
        if (cke) begin
            if (!rst_n) begin
                mdl_busy = 1'b0;
                mdl_g    = 0;
                mdl_last = N - 1;
                idq.delete();
            end else begin
                if (s_rvalid && idq.size() > 0) void'(idq.pop_front());
                if (exp_acc && isRead(mdl_g)) idq.push_back(mdl_g);
                if (exp_acc) begin
                    drop     = 1'b1;
                    drop_idx = mdl_g;
                end
                if (!mdl_busy) begin
                    if (|m_av) begin
                        mdl_g    = rrNext(mdl_last, m_av);
                        mdl_last = mdl_g;
                        mdl_busy = 1'b1;
                    end
                end else if (exp_acc) begin
`ifdef IOB_RR_MERGE_B2B_EN
                    others = m_av;
                    others[mdl_g] = 1'b0;
                    if (|others) begin
                        mdl_g    = rrNext(mdl_g, others);
                        mdl_last = mdl_g;
                    end else begin
                        mdl_busy = 1'b0;
                    end
`else
                    mdl_busy = 1'b0;
`endif
                end else if (!m_av[mdl_g]) begin
                    mdl_busy = 1'b0;
                end
            end
        end
        @(posedge clk);
        #1;
        if (drop) m_av[drop_idx] = 1'b0;
        s_rvalid = 1'b0;
    endtask

    task automatic cycle(input string tag);
        checkOutput(tag);
        advance();
    endtask

    task automatic doReset();
        m_av     = '0;
        s_rvalid = 1'b0;
        cke      = 1'b1;
        rst_n    = 1'b0;
        cycle("rst");
        rst_n    = 1'b1;
    endtask

    // Random traffic: idle masters may post a new read or write, and the slave
    // randomly stalls and returns reads in order.
    task automatic applyStimulus();
        for (int i = 0; i < N; i++) begin
            if (!m_av[i] && $urandom_range(0, 2) == 0) begin
                setReq(i, AW'($urandom), DW'($urandom),
                       ($urandom_range(0, 1) == 1) ? SW'(0) : SW'($urandom_range(1, 15)));
            end
        end
        cke      = ($urandom_range(0, 15) != 0);
        s_ready  = ($urandom_range(0, 3) != 0);
        s_rvalid = cke && (idq.size() > 0) && ($urandom_range(0, 1) == 1);
        s_rdata  = DW'($urandom);
    endtask

    initial begin
        cke = 1'b1; rst_n = 1'b0; m_av = '0; m_addr = '0; m_wdata = '0; m_wstrb = '0;
        s_rdata = '0; s_rvalid = 1'b0; s_ready = 1'b0;
        mdl_busy = 1'b0; mdl_g = 0; mdl_last = N - 1;

        // Reset state
        cycle("rst0");
        check_en = 1'b1;
        cycle("rst1");
        rst_n = 1'b1;

        // Single write from master 0
        setReq(0, 'h10, 'hA5A5A5A5, 'hF);
        s_ready = 1'b1;
        checkOutput("t1_idle");
        checkValue("t1_idle_savalid", s_avalid, 0);
        advance();
        checkOutput("t1_busy");
        checkValue("t1_busy_savalid", s_avalid, 1);
        checkValue("t1_busy_mready", m_ready, 3'b001);
        checkValue("t1_busy_saddr", s_addr, 'h10);
        advance();
        checkOutput("t1_after");
        checkValue("t1_after_mready", m_ready, 0);
        checkValue("t1_after_rvalid", m_rvalid, 0);
        checkValue("t1_after_saddr", s_addr, 0);
        advance();

        // Two masters alternate reads, and data returns one cycle after accept
        doReset();
        s_ready = 1'b1;
        for (int t = 0; t <= 8; t++) begin
            if (t < 5 && !m_av[0]) setReq(0, AW'('h100 + t), 0, 0);
            if (t < 7 && !m_av[1]) setReq(1, AW'('h200 + t), 0, 0);
            s_rvalid = (t >= 2 && t % 2 == 0);
            s_rdata  = DW'(t / 2);
            checkOutput("t2");
`ifndef IOB_RR_MERGE_B2B_EN
            if (t % 2 == 1) checkValue("t2_grant", m_ready, 1 << ((t / 2) % 2));
            if (t >= 2 && t % 2 == 0) begin
                checkValue("t2_route", m_rvalid, 1 << ((t / 2 - 1) % 2));
                checkValue("t2_rdata", m_rdata[DW-1:0], t / 2);
            end
`endif
            advance();
        end

        // Reads stall while the ID FIFO is full and resume after one pop
        doReset();
        s_ready = 1'b1;
        for (int t = 0; t <= 11; t++) begin
            if (!m_av[0]) setReq(0, AW'('h300 + t), 0, 0);
            s_rvalid = (t == 10);
            s_rdata  = 'h77;
            checkOutput("t3");
            if (t < 8 && t % 2 == 1) checkValue("t3_accept", m_ready, 3'b001);
            if (t == 9 || t == 10) begin
                checkValue("t3_gated_savalid", s_avalid, 0);
                checkValue("t3_gated_mready", m_ready, 0);
            end
            if (t == 10) checkValue("t3_pop_rvalid", m_rvalid, 3'b001);
            if (t == 11) checkValue("t3_resume", s_avalid, 1);
            advance();
        end
        for (int k = 0; k < 4; k++) begin
            s_rvalid = 1'b1;
            s_rdata  = DW'(k);
            cycle("t3_drain");
        end

        // Master 1 withdraws while granted, so master 0 is served next
        doReset();
        s_ready = 1'b0;
        setReq(1, 'h400, 'h11, 'hF);
        cycle("t4_idle");
        checkOutput("t4_wait");
        checkValue("t4_wait_savalid", s_avalid, 1);
        checkValue("t4_wait_mready", m_ready, 0);
        advance();
        m_av[1] = 1'b0;
        setReq(0, 'h500, 'h22, 'hF);
        s_ready = 1'b1;
        checkOutput("t4_drop");
        checkValue("t4_drop_savalid", s_avalid, 0);
        checkValue("t4_drop_mready", m_ready, 0);
        advance();
        cycle("t4_idle2");
        checkOutput("t4_m0");
        checkValue("t4_m0_mready", m_ready, 3'b001);
        checkValue("t4_m0_saddr", s_addr, 'h500);
        advance();

        // Reset with two reads outstanding, then a stale response arrives
        doReset();
        s_ready = 1'b1;
        for (int t = 0; t < 4; t++) begin
            if (t < 3 && !m_av[0]) setReq(0, AW'('h600 + t), 0, 0);
            cycle("t5_fill");
        end
        rst_n = 1'b0;
        cycle("t5_rst");
        rst_n = 1'b1;
        s_rvalid = 1'b1;
        s_rdata  = 'h55;
        checkOutput("t5_stale");
        checkValue("t5_stale_rvalid", m_rvalid, 0);
        advance();
        setReq(1, 'h680, 0, 0);
        cycle("t5_idle");
        cycle("t5_busy");
        s_rvalid = 1'b1;
        s_rdata  = 'h66;
        checkOutput("t5_route");
        checkValue("t5_route_rvalid", m_rvalid, 3'b010);
        advance();

        // A low clock enable freezes the grant
        setReq(2, 'h700, 'h33, 'hF);
        s_ready = 1'b1;
        cycle("t6_idle");
        cke = 1'b0;
        checkOutput("t6_frozen");
        checkValue("t6_frozen_mready", m_ready, 3'b100);
        advance();
        cke = 1'b1;
        checkOutput("t6_thaw");
        checkValue("t6_thaw_mready", m_ready, 3'b100);
        advance();
        cycle("t6_after");

`ifdef IOB_RR_MERGE_B2B_EN
        // Back-to-back writes from three masters
        doReset();
        s_ready = 1'b1;
        for (int t = 0; t <= 4; t++) begin
            for (int i = 0; i < N; i++) begin
                if (!m_av[i]) setReq(i, AW'('h800 + t * 16 + i), DW'(t), 'hF);
            end
            checkOutput("t7");
            if (t >= 1) begin
                checkValue("t7_savalid", s_avalid, 1);
                checkValue("t7_order", m_ready, 1 << ((t - 1) % 3));
            end
            advance();
        end
        m_av = '0;
        cycle("t7_end");
`endif

        // Randomized traffic against the model
        doReset();
        for (int n = 0; n < 3000; n++) begin
            applyStimulus();
            cycle("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
